// File: rtl/bpb_if.sv
// Fetch-side lookup and decode-side update signals of the branch prediction buffer.
interface bpb_if;
  logic [31:0] lookup_pc;
  logic        predict_hit;
  logic        predict_taken;
  logic [31:0] predict_adr;
  logic        update_en;
  logic        stall;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] mispredict_cnt;

  modport master (
    output lookup_pc, update_en, stall, update_pc, update_taken, update_target,
           update_pred_taken,
    input  predict_hit, predict_taken, predict_adr, mispredict_cnt
  );

  modport slave (
    input  lookup_pc, update_en, stall, update_pc, update_taken, update_target,
           update_pred_taken,
    output predict_hit, predict_taken, predict_adr, mispredict_cnt
  );
endinterface

// File: rtl/bpb_assoc.sv
// Set-associative branch prediction buffer with per-set age LRU and saturating counters.
// Define BPB_GHR_EN to XOR a global taken-history register into the set index.
module bpb_assoc #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int TAG_W = 8,
  parameter int CTR_W = 2,
  parameter int GHR_W = 4
) (
  input  logic  clk,
  input  logic  reset,
  bpb_if.slave  bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [AGE_W-1:0] AGE_OLD  = AGE_W'(WAYS-1);

  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [CTR_W-1:0] ctr_q   [SETS][WAYS];
  logic [31:0]      tgt_q   [SETS][WAYS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];
  logic [31:0]      miscnt_q, miscnt_d;

  logic [IDX_W-1:0] hist;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit;
  logic [CTR_W-1:0] lk_ctr;
  logic [31:0]      lk_tgt;
  logic             acc, wr_en, up_hit, vic_found;
  logic [AGE_W-1:0] hit_way, vic_way, lru_way, tw, old_age;
  logic [CTR_W-1:0] ctr_d;
  logic [31:0]      tgt_d;
  logic [AGE_W-1:0] age_d [WAYS];
  logic             unused_pc;

  function automatic logic [CTR_W-1:0] ctr_sat_inc(input logic [CTR_W-1:0] c);
    return (c == {CTR_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_W-1:0] ctr_sat_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

`ifdef BPB_GHR_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;
  assign ghr_d = GHR_W'({ghr_q, bus.update_taken});
  assign hist  = IDX_W'(ghr_q);
`else
  assign hist  = '0;
`endif

  assign unused_pc = ^{bus.lookup_pc, bus.update_pc};
  assign lk_idx    = bus.lookup_pc[2 +: IDX_W] ^ hist;
  assign lk_tag    = bus.lookup_pc[2+IDX_W +: TAG_W];
  assign up_idx    = bus.update_pc[2 +: IDX_W] ^ hist;
  assign up_tag    = bus.update_pc[2+IDX_W +: TAG_W];
  assign acc       = bus.update_en & ~bus.stall;

  // Fetch lookup: pure read of the current state, no LRU side effects.
  always_comb begin
    lk_hit = 1'b0;
    lk_ctr = '0;
    lk_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_ctr = ctr_q[lk_idx][w];
        lk_tgt = tgt_q[lk_idx][w];
      end
    end
  end

  assign bus.predict_hit    = lk_hit;
  assign bus.predict_taken  = lk_hit & lk_ctr[CTR_W-1];
  assign bus.predict_adr    = (lk_hit & lk_ctr[CTR_W-1]) ? lk_tgt : bus.lookup_pc + 32'd4;
  assign bus.mispredict_cnt = miscnt_q;

  // Decode update: pick the touched way, then derive its new entry and the set's ages.
  always_comb begin
    up_hit    = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit  = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[up_idx][w] == AGE_OLD) lru_way = AGE_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = AGE_W'(w);
      end
    end
    tw      = up_hit ? hit_way : (vic_found ? vic_way : lru_way);
    wr_en   = acc & (up_hit | bus.update_taken);
    old_age = age_q[up_idx][tw];
    if (up_hit)
      ctr_d = bus.update_taken ? ctr_sat_inc(ctr_q[up_idx][tw]) : ctr_sat_dec(ctr_q[up_idx][tw]);
    else
      ctr_d = CTR_INIT;
    tgt_d = bus.update_taken ? bus.update_target : tgt_q[up_idx][tw];
    for (int w = 0; w < WAYS; w++) begin
      age_d[w] = age_q[up_idx][w];
      if (AGE_W'(w) == tw)                 age_d[w] = '0;
      else if (age_q[up_idx][w] < old_age) age_d[w] = age_q[up_idx][w] + 1'b1;
    end
    miscnt_d = miscnt_q;
    if (acc && (bus.update_pred_taken != bus.update_taken))
      miscnt_d = cnt_sat_inc(miscnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          ctr_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
      miscnt_q <= '0;
`ifdef BPB_GHR_EN
      ghr_q    <= '0;
`endif
    end else begin
      if (wr_en) begin
        valid_q[up_idx][tw] <= 1'b1;
        tag_q[up_idx][tw]   <= up_tag;
        ctr_q[up_idx][tw]   <= ctr_d;
        tgt_q[up_idx][tw]   <= tgt_d;
        for (int w = 0; w < WAYS; w++) age_q[up_idx][w] <= age_d[w];
      end
      miscnt_q <= miscnt_d;
`ifdef BPB_GHR_EN
      if (acc) ghr_q <= ghr_d;
`endif
    end
  end
endmodule
